// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution window sequencer.
//   - default image geometry and pixel address width
//   - scheduler state encoding
//   - number of windows produced per frame for the default geometry
package conv_pkg;

  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;
  localparam int DEF_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Stride-1, unpadded 3x3 windows over an h x w image.
  function automatic int win_count(input int h, input int w);
    return (h - 2) * (w - 2);
  endfunction

  localparam int WIN_CNT = win_count(DEF_IMG_H, DEF_IMG_W);

endpackage

// File: rtl/win_addr_regs.sv
// win_addr_regs: top-left row/col of the current 3x3 window plus the nine
// tap addresses, all held in the same register stage so the addresses are
// valid in the same cycle as row/col.
//   clk, rst       : clock, synchronous active-high reset (clears everything)
//   clear          : zero row/col and all taps
//   load           : load window (0,0)
//   advance        : step to the next window in raster order
//   wrap           : with advance, move to column 0 of the next row
//   row, col       : top-left coordinate of the current window
//   pa             : tap addresses, index k = (r-1)*3 + (c-1)
module win_addr_regs #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6,
  parameter int RW     = $clog2(IMG_H),
  parameter int CW     = $clog2(IMG_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 wrap,
  output logic [RW-1:0]        row,
  output logic [CW-1:0]        col,
  output logic [8:0][ADDR_W-1:0] pa
);

  // Moving from column IMG_W-3 of one row to column 0 of the next advances
  // every tap by IMG_W - (IMG_W-3) = 3 addresses.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(1);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
      pa  <= '0;
    end else if (load) begin
      row <= '0;
      col <= '0;
      for (int k = 0; k < 9; k++) begin
        pa[k] <= ADDR_W'((k / 3) * IMG_W + (k % 3));
      end
    end else if (advance) begin
      if (wrap) begin
        row <= row + RW'(1);
        col <= '0;
        for (int k = 0; k < 9; k++) begin
          pa[k] <= pa[k] + ROW_STEP;
        end
      end else begin
        col <= col + CW'(1);
        for (int k = 0; k < 9; k++) begin
          pa[k] <= pa[k] + COL_STEP;
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// conv_window_sched: walks an IMG_H x IMG_W image with a 3x3, stride-1,
// unpadded window and presents the nine tap addresses of each window to the
// pixel RAM / filter MAC over a valid/ready handshake.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a frame (honoured only in IDLE)
//   busy              : frame in progress (equals win_valid)
//   done              : one-cycle pulse after the final window is accepted
//   win_valid/ready   : window handshake, one window per accepting cycle
//   win_last          : current window is the last of the frame
//   win_row, win_col  : top-left coordinate of the current window
//   pa11..pa33        : tap addresses, (row+r-1)*IMG_W + (col+c-1)
// All outputs come straight from registers.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       win_last,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic [ADDR_W-1:0]          pa11,
  output logic [ADDR_W-1:0]          pa12,
  output logic [ADDR_W-1:0]          pa13,
  output logic [ADDR_W-1:0]          pa21,
  output logic [ADDR_W-1:0]          pa22,
  output logic [ADDR_W-1:0]          pa23,
  output logic [ADDR_W-1:0]          pa31,
  output logic [ADDR_W-1:0]          pa32,
  output logic [ADDR_W-1:0]          pa33
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 3);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 3);
  localparam bit SINGLE_WIN = (win_count(IMG_H, IMG_W) == 1);

  if (IMG_W < 3 || IMG_H < 3 || (64'(1) << ADDR_W) < 64'(IMG_W * IMG_H)) begin : g_bad_params
    $error("conv_window_sched: illegal IMG_W/IMG_H/ADDR_W combination");
  end

  sched_state_t state_q, state_d;
  logic run_q, done_q, last_q, last_d;
  logic load, clear, advance, wrap;
  logic [RW-1:0] row, nrow;
  logic [CW-1:0] col, ncol;
  logic [8:0][ADDR_W-1:0] pa;

  win_addr_regs #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .RW     (RW),
    .CW     (CW)
  ) u_addr (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .load    (load),
    .advance (advance),
    .wrap    (wrap),
    .row     (row),
    .col     (col),
    .pa      (pa)
  );

  // NOTE: every signal written here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    wrap    = 1'b0;
    nrow    = row;
    ncol    = col;
    last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
          last_d  = SINGLE_WIN;
        end
      end
      RUN: begin
        // win_valid is high throughout RUN, so win_ready alone is an accept.
        last_d = last_q;
        if (win_ready) begin
          if (last_q) begin
            state_d = DONE;
            clear   = 1'b1;
            last_d  = 1'b0;
          end else begin
            advance = 1'b1;
            wrap    = (col == COL_MAX);
            nrow    = wrap ? row + RW'(1) : row;
            ncol    = wrap ? '0 : col + CW'(1);
            // Registered so win_last lines up with the window it qualifies.
            last_d  = (nrow == ROW_MAX) && (ncol == COL_MAX);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      last_q  <= last_d;
    end
  end

  assign busy      = run_q;
  assign win_valid = run_q;
  assign done      = done_q;
  assign win_last  = last_q;
  assign win_row   = row;
  assign win_col   = col;
  assign pa11      = pa[0];
  assign pa12      = pa[1];
  assign pa13      = pa[2];
  assign pa21      = pa[3];
  assign pa22      = pa[4];
  assign pa23      = pa[5];
  assign pa31      = pa[6];
  assign pa32      = pa[7];
  assign pa33      = pa[8];

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched with IMG_W = IMG_H = 8.
module tb_conv_window_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       win_ready;
  logic       busy, done, win_valid, win_last;
  logic [2:0] win_row, win_col;
  logic [5:0] pa11, pa12, pa13, pa21, pa22, pa23, pa31, pa32, pa33;
  logic [5:0] pa_obs [9];
  logic [62:0] snap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_sched #(.IMG_W(8), .IMG_H(8), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last),
    .win_row   (win_row),
    .win_col   (win_col),
    .pa11      (pa11),
    .pa12      (pa12),
    .pa13      (pa13),
    .pa21      (pa21),
    .pa22      (pa22),
    .pa23      (pa23),
    .pa31      (pa31),
    .pa32      (pa32),
    .pa33      (pa33)
  );

  assign pa_obs[0] = pa11;
  assign pa_obs[1] = pa12;
  assign pa_obs[2] = pa13;
  assign pa_obs[3] = pa21;
  assign pa_obs[4] = pa22;
  assign pa_obs[5] = pa23;
  assign pa_obs[6] = pa31;
  assign pa_obs[7] = pa32;
  assign pa_obs[8] = pa33;
  assign snap = {win_row, win_col, win_last, win_valid, busy,
                 pa11, pa12, pa13, pa21, pa22, pa23, pa31, pa32, pa33};

  // Reference address of tap k for the window whose top-left is (r,c).
  function automatic int exp_pa(input int r, input int c, input int k);
    return (r + k / 3) * 8 + c + (k % 3);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; win_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, done, win_valid, win_last, win_row, win_col} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected all zero",
               {busy, done, win_valid, win_last, win_row, win_col});
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (pa_obs[k] !== 6'd0) begin
        errors++;
        $display("FAIL reset_pa%0d: got %0d expected 0", k, pa_obs[k]);
      end
    end
    rst = 1'b0; start = 1'b0; win_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_hold: busy=%b valid=%b expected 0 0", busy, win_valid);
    end
  endtask

  // mode 0: win_ready always high; 1: 50% random backpressure;
  // 2: win_ready high with start pulses during RUN and DONE.
  task automatic test_frame_walk(input int mode);
    int exp_r = 0, exp_c = 0, accepts = 0, cycles = 0;
    bit rdy;
    logic [62:0] prev;
    int first_win [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int wrap_win  [9] = '{8, 9, 10, 16, 17, 18, 24, 25, 26};
    int last_win  [9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};

    win_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev = snap;
    rdy = 1'b1;
    while (accepts < 36 && cycles < 2000) begin
      checks++;
      if (busy !== 1'b1 || win_valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL m%0d_run_flags @acc%0d: busy=%b valid=%b done=%b expected 1 1 0",
                 mode, accepts, busy, win_valid, done);
      end
      checks++;
      if (win_row !== 3'(exp_r) || win_col !== 3'(exp_c)) begin
        errors++;
        $display("FAIL m%0d_rowcol @acc%0d: got (%0d,%0d) expected (%0d,%0d)",
                 mode, accepts, win_row, win_col, exp_r, exp_c);
      end
      checks++;
      if (win_last !== ((exp_r == 5) && (exp_c == 5))) begin
        errors++;
        $display("FAIL m%0d_last @acc%0d: got %b expected %b",
                 mode, accepts, win_last, (exp_r == 5) && (exp_c == 5));
      end
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (pa_obs[k] !== 6'(exp_pa(exp_r, exp_c, k))) begin
          errors++;
          $display("FAIL m%0d_pa%0d @(%0d,%0d): got %0d expected %0d",
                   mode, k, exp_r, exp_c, pa_obs[k], exp_pa(exp_r, exp_c, k));
        end
      end
      if (mode == 0 && ((exp_r == 0 && exp_c == 0) || (exp_r == 1 && exp_c == 0) ||
                        (exp_r == 5 && exp_c == 5))) begin
        for (int k = 0; k < 9; k++) begin
          int want;
          want = (exp_r == 0) ? first_win[k] : (exp_r == 1) ? wrap_win[k] : last_win[k];
          checks++;
          if (pa_obs[k] !== 6'(want)) begin
            errors++;
            $display("FAIL m0_table_pa%0d @(%0d,%0d): got %0d expected %0d",
                     k, exp_r, exp_c, pa_obs[k], want);
          end
        end
      end
      if (!rdy) begin
        checks++;
        if (snap !== prev) begin
          errors++;
          $display("FAIL m%0d_stall_stable @acc%0d: got %h expected %h",
                   mode, accepts, snap, prev);
        end
      end
      prev = snap;
      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      win_ready = rdy;
      start = (mode == 2) && (cycles == 5 || cycles == 20);
      @(negedge clk);
      cycles++;
      if (rdy) begin
        accepts++;
        if (exp_c < 5) exp_c++;
        else begin exp_c = 0; exp_r++; end
      end
    end
    win_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (accepts != 36) begin
      errors++;
      $display("FAIL m%0d_accept_count: got %0d expected 36 (cycle bound hit)", mode, accepts);
    end
    if (mode != 1) begin
      checks++;
      if (cycles != 36) begin
        errors++;
        $display("FAIL m%0d_frame_cycles: got %0d expected 36", mode, cycles);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL m%0d_done_pulse: done=%b busy=%b valid=%b expected 1 0 0",
               mode, done, busy, win_valid);
    end
    start = (mode == 2);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || win_valid !== 1'b0 || win_last !== 1'b0) begin
      errors++;
      $display("FAIL m%0d_back_to_idle: done=%b busy=%b valid=%b last=%b expected 0 0 0 0",
               mode, done, busy, win_valid, win_last);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL m%0d_idle_stays: busy=%b expected 0", mode, busy);
    end
  endtask

  task automatic test_reset_midframe();
    win_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    checks++;
    if (win_row !== 3'd1 || win_col !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre_pos: got (%0d,%0d) expected (1,3)", win_row, win_col);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    win_ready = 1'b0;
    checks++;
    if ({busy, done, win_valid, win_last, win_row, win_col} !== 10'b0 || snap !== 63'b0) begin
      errors++;
      $display("FAIL rst_mid_zero: got %h expected 0", snap);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (win_valid !== 1'b1 || win_row !== 3'd0 || win_col !== 3'd0 ||
        pa11 !== 6'd0 || pa13 !== 6'd2 || pa33 !== 6'd18) begin
      errors++;
      $display("FAIL rst_restart: valid=%b (%0d,%0d) pa11=%0d pa13=%0d pa33=%0d expected 1 (0,0) 0 2 18",
               win_valid, win_row, win_col, pa11, pa13, pa33);
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_run: busy=%b valid=%b expected 0 0", busy, win_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0 || pa12 !== 6'd0) begin
      errors++;
      $display("FAIL rst_start_idle: busy=%b valid=%b pa12=%0d expected 0 0 0",
               busy, win_valid, pa12);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_idle: busy=%b expected 0", busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b0;
    test_reset();
    test_frame_walk(0);
    test_frame_walk(1);
    test_frame_walk(2);
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Sequencer that walks a stored IMG_H x IMG_W image with a 3x3 window (stride 1, no padding) and issues the nine pixel addresses of each window to the image RAM read ports that feed the 3x3 filter MAC. It sits between the top-level control (start/done) and the pixel RAM plus filter datapath. The MAC consumes windows through a valid/ready handshake. One window is accepted per cycle when the consumer is ready.

## Interface
- IMG_W, 8, image width in pixels (>= 3)
- IMG_H, 8, image height in pixels (>= 3)
- ADDR_W, 6, pixel address width, >= clog2(IMG_W*IMG_H)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse after the final window is accepted
- win_valid  out  1  window addresses valid
- win_ready  in  1  consumer accepts the window this cycle
- win_last  out  1  qualifies the final window of the frame
- win_row  out  clog2(IMG_H)  top-left row of the current window
- win_col  out  clog2(IMG_W)  top-left column of the current window
- pa11..pa33  out  ADDR_W each  pixel address of window tap (r,c), r,c in 1..3

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1, go to RUN with row=0 and col=0. Otherwise hold. All outputs are 0.
- RUN: win_valid=1. Addresses are pa_rc = (row+r-1)*IMG_W + (col+c-1).
- RUN, accept (win_valid & win_ready):
  - if col < IMG_W-3, col increments;
  - otherwise col=0 and row increments.
- win_last=1 when row=IMG_H-3 and col=IMG_W-3. Accepting the last window moves the FSM to DONE.
- DONE: done=1, busy=0, win_valid=0 for exactly one cycle, then IDLE.
- Stall: while win_valid=1 and win_ready=0, all win_* and pa* outputs hold bit-stable.
- start while in RUN or DONE is ignored. No queueing, no restart.
- Frame produces exactly (IMG_H-2)*(IMG_W-2) accepted windows.
- Arithmetic:
  - row and col are unsigned and never exceed IMG_H-3 / IMG_W-3.
  - Addresses are unsigned ADDR_W and cannot overflow for legal parameters.
  - Parameter legality is checked by elaboration-time assertion.
- Reset (any state, including mid-frame): next cycle IDLE, with all outputs 0 and row/col 0. The partial frame is abandoned.
- rst and start asserted together: reset wins.

## Timing
- All outputs are registered. No combinational path from win_ready or start to any output.
- start=1 in IDLE at edge T: at T+1, busy=1, win_valid=1, window (0,0).
- Address latency from row/col update to pa* is 0 cycles. Addresses are computed into the same registers as row/col (incremental: +1 per column step, +3 to next row base on row wrap).
- win_ready held high gives one window per cycle. The final accept is at edge T+N, with N = (IMG_H-2)*(IMG_W-2).
- After the final accept, done=1 at T+N+1 and the FSM is IDLE at T+N+2. The earliest next start is accepted at T+N+2.
- busy and win_valid are identical in RUN. Both are low in IDLE and DONE.

## Structure
- Shared package conv_pkg:
  - IMG_W, IMG_H, ADDR_W defaults;
  - state enum sched_state_t {IDLE, RUN, DONE};
  - localparam WIN_CNT = (IMG_H-2)*(IMG_W-2).
- One sub-module, win_addr_regs:
  - holds row/col and the nine pa* registers;
  - ports: advance, wrap, clear;
  - does the incremental address update.
- The FSM and handshake live in conv_window_sched.

## Test plan
All scenarios use IMG_W=IMG_H=8.
- Reset then start, win_ready=1. Required response:
  - at T+1, window (0,0) with pa11..pa33 = 0,1,2,8,9,10,16,17,18;
  - 36 windows on consecutive cycles;
  - done pulse at T+37;
  - IDLE at T+38.
- Row wrap: the window after (0,5) is (1,0) with pa11..pa33 = 8,9,10,16,17,18,24,25,26. The final window (5,5) is 45,46,47,53,54,55,61,62,63 with win_last=1.
- Random win_ready backpressure (50%). Required response:
  - outputs bit-stable on every stalled cycle;
  - exactly 36 accepts, in raster order;
  - done occurs only after the 36th accept.
- start pulsed during RUN and during DONE: ignored. The window sequence and the count of 36 are unchanged.
- rst asserted at the 10th accept. Required response:
  - next cycle all outputs 0 in IDLE;
  - a new start restarts at window (0,0);
  - rst and start together keep the FSM in IDLE.
